score_bcd_accumulator: RTL

SCORE_BCD_ACCUMULATOR -- requirements
Module: score_bcd_accumulator

---
 rtl/score_bcd_accumulator_pkg.sv | 24 ++
 rtl/score_bcd_accumulator_digit_add.sv | 22 ++
 rtl/score_bcd_accumulator.sv | 139 +++++++++++++
 3 files changed

// File: rtl/score_bcd_accumulator_pkg.sv
// Shared state encoding, BCD constants and point clamping for the score accumulator.
package score_bcd_accumulator_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_D0   = 3'd1,
      ST_D1   = 3'd2,
      ST_D2   = 3'd3,
      ST_D3   = 3'd4,
      ST_HS   = 3'd5
   } state_e;

   // [3] = thousands ... [0] = ones
   typedef logic [3:0][3:0] bcd_score_t;

   localparam logic [3:0] BCD_DIGIT_MAX  = 4'd9;
   localparam bcd_score_t BCD_SCORE_MAX  = 16'h9999;
   localparam bcd_score_t BCD_SCORE_ZERO = 16'h0000;

   function automatic logic [3:0] clamp_points(input logic [3:0] pts);
      return (pts > BCD_DIGIT_MAX) ? BCD_DIGIT_MAX : pts;
   endfunction

endpackage

// File: rtl/score_bcd_accumulator_digit_add.sv
// Single BCD digit adder: digit (0..9) plus carry-in (0..9) giving a BCD digit and carry-out.
module score_bcd_accumulator_digit_add (
   input  logic [3:0] digit_i,
   input  logic [3:0] carry_i,
   output logic [3:0] sum_o,
   output logic       carry_o
);

   logic [4:0] raw;

   always_comb begin
      raw = {1'b0, digit_i} + {1'b0, carry_i};
      if (raw >= 5'd10) begin
         sum_o   = 4'(raw - 5'd10);
         carry_o = 1'b1;
      end else begin
         sum_o   = raw[3:0];
         carry_o = 1'b0;
      end
   end

endmodule

// File: rtl/score_bcd_accumulator.sv
// Four-digit BCD score accumulator with high-score tracking; one digit is added per cycle
// through a shared digit adder and the result is committed to the display atomically.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | ready for an add request
// D0..D3  | add carry into working digit n (D3 also commits the score)
// HS      | compare committed score against high score, update if larger
module score_bcd_accumulator
   import score_bcd_accumulator_pkg::*;
#(
   parameter bit SATURATE = 1'b1
) (
   input  logic       clk_sys_i,
   input  logic       rst_b_i,
   input  logic       clear_i,
   input  logic       add_valid_i,
   input  logic [3:0] add_points_i,
   output logic       add_ready_o,
   output logic [3:0] score_thousands_o,
   output logic [3:0] score_hundreds_o,
   output logic [3:0] score_tens_o,
   output logic [3:0] score_ones_o,
   output logic [3:0] high_thousands_o,
   output logic [3:0] high_hundreds_o,
   output logic [3:0] high_tens_o,
   output logic [3:0] high_ones_o,
   output logic       new_high_o,
   output logic       saturated_o
);

   state_e     state_q;
   bcd_score_t work_q;
   bcd_score_t score_q;
   bcd_score_t high_q;
   logic [3:0] carry_q;
   logic       sat_q;
   logic       new_high_q;
   logic       ready_q;

   logic [1:0] digit_idx;
   logic [3:0] sum_w;
   logic       carry_w;
   logic       high_beaten;

   always_comb begin
      digit_idx = 2'd0;
      case (state_q)
         ST_D1:   digit_idx = 2'd1;
         ST_D2:   digit_idx = 2'd2;
         ST_D3:   digit_idx = 2'd3;
         default: digit_idx = 2'd0;
      endcase
   end

   score_bcd_accumulator_digit_add u_digit_add (
      .digit_i (work_q[digit_idx]),
      .carry_i (carry_q),
      .sum_o   (sum_w),
      .carry_o (carry_w)
   );

   // Packed BCD digits order the same way as the numbers they encode.
   assign high_beaten = (score_q > high_q);

   always_ff @(posedge clk_sys_i) begin
      if (!rst_b_i) begin
         state_q    <= ST_IDLE;
         work_q     <= BCD_SCORE_ZERO;
         score_q    <= BCD_SCORE_ZERO;
         high_q     <= BCD_SCORE_ZERO;
         carry_q    <= 4'd0;
         sat_q      <= 1'b0;
         new_high_q <= 1'b0;
         ready_q    <= 1'b1;
      end else if (clear_i) begin
         state_q    <= ST_IDLE;
         work_q     <= BCD_SCORE_ZERO;
         score_q    <= BCD_SCORE_ZERO;
         carry_q    <= 4'd0;
         sat_q      <= 1'b0;
         new_high_q <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         new_high_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (add_valid_i) begin
                  work_q  <= score_q;
                  carry_q <= clamp_points(add_points_i);
                  state_q <= ST_D0;
                  ready_q <= 1'b0;
               end
            end
            ST_D0, ST_D1, ST_D2: begin
               work_q[digit_idx] <= sum_w;
               carry_q           <= {3'b000, carry_w};
               state_q           <= state_e'(state_q + 3'd1);
            end
            ST_D3: begin
               work_q[3] <= sum_w;
               carry_q   <= 4'd0;
               if (carry_w) begin
                  sat_q   <= 1'b1;
                  score_q <= SATURATE ? BCD_SCORE_MAX : {sum_w, work_q[2], work_q[1], work_q[0]};
               end else begin
                  score_q <= {sum_w, work_q[2], work_q[1], work_q[0]};
               end
               state_q <= ST_HS;
            end
            ST_HS: begin
               if (high_beaten) begin
                  high_q     <= score_q;
                  new_high_q <= 1'b1;
               end
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign add_ready_o       = ready_q;
   assign score_thousands_o = score_q[3];
   assign score_hundreds_o  = score_q[2];
   assign score_tens_o      = score_q[1];
   assign score_ones_o      = score_q[0];
   assign high_thousands_o  = high_q[3];
   assign high_hundreds_o   = high_q[2];
   assign high_tens_o       = high_q[1];
   assign high_ones_o       = high_q[0];
   assign new_high_o        = new_high_q;
   assign saturated_o       = sat_q;

endmodule
